// File: rtl/encoder_sample_scheduler.sv
// ---------------------------------------------------------------------------
// encoder_sample_scheduler
//
// Purpose: once per sample period, pulses a common latch/clear to a bank of
// quadrature encoder channels, reads each latched count over a shared muxed
// bus and removes the zero-motion rest offset. It then commits all deltas at
// once into a snapshot that a consumer reads and acknowledges.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   en           sampling enable (period counter runs only while high)
//   cfg_we       strobe that loads cfg_period into the pending period
//   cfg_period   requested sample period in clk cycles (clamped to MINP)
//   enc_latch    one-cycle pulse: all channels latch their count and restart
//   enc_sel      channel index driven onto the shared read bus
//   enc_data     latched count of the channel selected on the previous cycle
//   rd_ch        snapshot read index
//   rd_data      signed delta of snapshot[rd_ch], 0 for rd_ch >= NUM_CH
//   frame_valid  a committed snapshot is waiting for frame_ack
//   frame_ack    consumer has taken the snapshot
//   frame_cnt    committed frame count, wraps modulo 2^16
//   overrun      sticky: a commit overwrote an unacknowledged frame
// ---------------------------------------------------------------------------
module encoder_sample_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 32,
    parameter int OFFSET         = 4192,
    parameter int SETTLE_CYC     = 4,
    parameter int DEFAULT_PERIOD = 500000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      cfg_we,
    input  logic [31:0]               cfg_period,
    output logic                      enc_latch,
    output logic [$clog2(NUM_CH)-1:0] enc_sel,
    input  logic [CNT_W-1:0]          enc_data,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic [CNT_W-1:0]          rd_data,
    output logic                      frame_valid,
    input  logic                      frame_ack,
    output logic [15:0]               frame_cnt,
    output logic                      overrun
);

    localparam int SEL_W  = $clog2(NUM_CH);
    // Shortest period that still lets one whole frame finish before the next tick.
    localparam int MINP   = SETTLE_CYC + NUM_CH + 4;
    localparam int STEP_W = $clog2(SETTLE_CYC + NUM_CH + 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);
    localparam logic [STEP_W-1:0] SETTLE_LAST = STEP_W'(SETTLE_CYC - 1);
    localparam logic [STEP_W-1:0] READ_LAST   = STEP_W'(NUM_CH);
    localparam logic [SEL_W-1:0]  SEL_ONE     = SEL_W'(1);
    localparam logic [CNT_W-1:0]  OFFSET_W    = CNT_W'(OFFSET);

    logic [31:0]       period_q, period_d;
    logic [31:0]       pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [31:0]       dt_q, dt_d;
    logic [31:0]       cfg_clamped;
    logic              tick;

    logic [2:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic [CNT_W-1:0]  snap_vec [NUM_CH];

    assign tick        = en && (dt_q == period_q - 32'd1);
    assign cfg_clamped = (cfg_period < 32'(MINP)) ? 32'(MINP) : cfg_period;

    // Period counter and period reconfiguration. A new period only takes
    // effect at a period boundary so the running period is never shortened.
    always_comb begin
        period_d   = period_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        dt_d       = dt_q + 32'd1;
        if (!en || tick) begin
            dt_d = '0;
        end
        if (pend_vld_q && (tick || !en)) begin
            period_d   = pend_q;
            pend_vld_d = 1'b0;
        end
        // A write in the same cycle as an apply becomes the next pending value.
        if (cfg_we) begin
            pend_d     = cfg_clamped;
            pend_vld_d = 1'b1;
        end
    end

    // Frame sequencer. step_q counts settle cycles and then read slots.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_SETTLE;
                step_d  = '0;
            end
            S_SETTLE: begin
                if (step_q == SETTLE_LAST) begin
                    state_d = S_READ;
                    step_d  = '0;
                    sel_d   = '0;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            S_READ: begin
                if (step_q == READ_LAST) begin
                    state_d = S_COMMIT;
                end else begin
                    step_d = step_q + STEP_ONE;
                    // Select advances up to the last channel, then holds.
                    if (step_q < READ_LAST - STEP_ONE) begin
                        sel_d = sel_q + SEL_ONE;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake: an ack coinciding with a commit belongs to the old frame,
    // so the new frame stays valid and no overrun is flagged.
    always_comb begin
        valid_d = valid_q;
        ovr_d   = ovr_q;
        fcnt_d  = fcnt_q;
        if (state_q == S_COMMIT) begin
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            if (valid_q && !frame_ack) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && frame_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q   <= 32'(DEFAULT_PERIOD);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            dt_q       <= '0;
            state_q    <= S_IDLE;
            step_q     <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            period_q   <= period_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            dt_q       <= dt_d;
            state_q    <= state_d;
            step_q     <= step_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Per-channel shadow (filled during READ) and snapshot (loaded only in
    // COMMIT, all channels together, so a reader never sees a mixed frame).
    // Read slot gi+1 carries the data of channel gi due to the bus latency.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] shadow_q;
            logic [CNT_W-1:0] snap_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_q <= '0;
                    snap_q   <= '0;
                end else begin
                    if (state_q == S_READ && step_q == STEP_W'(gi + 1)) begin
                        shadow_q <= enc_data - OFFSET_W;
                    end
                    if (state_q == S_COMMIT) begin
                        snap_q <= shadow_q;
                    end
                end
            end

            assign snap_vec[gi] = snap_q;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        if (32'(rd_ch) < NUM_CH) begin
            rd_data = snap_vec[rd_ch];
        end
    end

    assign enc_latch   = (state_q == S_LATCH);
    assign enc_sel     = sel_q;
    assign frame_valid = valid_q;
    assign frame_cnt   = fcnt_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_encoder_sample_scheduler
//
// Bench for encoder_sample_scheduler. A channel model latches bench-owned
// "live" counts on enc_latch and returns them with one cycle of read latency.
// A frame-level reference model predicts latch instants from the period,
// commit instants from the fixed frame latency, and the handshake state.
// DEFAULT_PERIOD is reduced so that the post-reset period fits a short run.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_encoder_sample_scheduler;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = $clog2(NUM_CH);
    localparam int OFFSET = 4192;
    localparam int SETTLE = 4;
    localparam int DEF_P  = 300;
    localparam int LAT    = SETTLE + NUM_CH + 3;   // enc_latch to frame_valid
    localparam int MINP   = SETTLE + NUM_CH + 4;

    typedef logic [NUM_CH-1:0][31:0] word4_t;
    typedef struct { int due; word4_t v; } frame_t;
    typedef struct { word4_t in_v; word4_t exp_v; } vec_t;

    logic             clk = 1'b0;
    logic             reset, en, cfg_we, frame_ack;
    logic [31:0]      cfg_period;
    logic             enc_latch;
    logic [SEL_W-1:0] enc_sel, rd_ch;
    logic [31:0]      enc_data, rd_data;
    logic             frame_valid, overrun;
    logic [15:0]      frame_cnt;

    encoder_sample_scheduler #(
        .NUM_CH(NUM_CH), .CNT_W(32), .OFFSET(OFFSET),
        .SETTLE_CYC(SETTLE), .DEFAULT_PERIOD(DEF_P)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we),
        .cfg_period(cfg_period), .enc_latch(enc_latch), .enc_sel(enc_sel),
        .enc_data(enc_data), .rd_ch(rd_ch), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_cnt(frame_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Channel model: counts captured on enc_latch, 1-cycle read latency.
    logic [31:0] live_val [NUM_CH];
    logic [31:0] lat_val  [NUM_CH];
    always @(posedge clk) begin
        if (enc_latch) begin
            for (int i = 0; i < NUM_CH; i++) lat_val[i] <= live_val[i];
        end
        enc_data <= lat_val[enc_sel];
    end

    int     cyc = 0, tests = 0, fails = 0;
    int     n_latch = 0, last_latch = -1;
    bit     m_valid, m_ovr, cap_pend, commit_now;
    logic [15:0] m_cnt;
    word4_t m_snap;
    int     m_period, m_pend, next_latch;
    frame_t fq[$];
    vec_t   vt[4];

    function automatic word4_t mk4(input logic [31:0] a, b, c, d);
        mk4 = {d, c, b, a};
    endfunction

    function automatic int clampp(input int v);
        clampp = (v < MINP) ? MINP : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic sweep_rd(input string name, input word4_t exp);
        logic [SEL_W-1:0] keep;
        keep = rd_ch;
        for (int k = 0; k < NUM_CH; k++) begin
            rd_ch = SEL_W'(k);
            #1;
            chk(name, rd_data, exp[k]);
        end
        rd_ch = keep;
    endtask

    // Advance one clock, update the reference model, compare outputs.
    task automatic step_cycle();
        frame_t f;
        bit     exp_latch;
        @(posedge clk);
        #1;
        cyc++;
        commit_now = 0;
        exp_latch  = 0;
        if (enc_latch) begin
            n_latch++;
            last_latch = cyc;
        end
        if (reset) begin
            m_valid = 0; m_ovr = 0; m_cnt = '0; m_snap = '0;
            m_period = DEF_P; m_pend = 0; cap_pend = 0;
            fq.delete();
            next_latch = en ? cyc + DEF_P : -1;
        end else begin
            if (cap_pend) begin
                for (int k = 0; k < NUM_CH; k++) f.v[k] = lat_val[k] - OFFSET;
                f.due = cyc - 1 + LAT;
                fq.push_back(f);
                cap_pend = 0;
            end
            if (next_latch == cyc) begin
                exp_latch = 1;
                if (m_pend != 0) begin
                    m_period = m_pend;
                    m_pend   = 0;
                end
                next_latch = cyc + m_period;
                cap_pend   = 1;
            end
            if (fq.size() > 0 && fq[0].due == cyc) begin
                f = fq.pop_front();
                if (m_valid && !frame_ack) m_ovr = 1;
                m_valid    = 1;
                m_cnt      = m_cnt + 16'd1;
                m_snap     = f.v;
                commit_now = 1;
            end else if (m_valid && frame_ack) begin
                m_valid = 0;
            end
        end
        chk("enc_latch", {31'd0, enc_latch}, {31'd0, exp_latch});
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_valid});
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("rd_data", rd_data, m_snap[rd_ch]);
        if (commit_now) sweep_rd("commit_snapshot", m_snap);
    endtask

    task automatic set_en(input bit v);
        en = v;
        if (v) begin
            next_latch = cyc + m_period;
        end else begin
            next_latch = -1;
            if (m_pend != 0) begin
                m_period = m_pend;
                m_pend   = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step_cycle();
        step_cycle();
        reset = 1'b0;
    endtask

    // Only used with en = 0: the pending value is applied right away.
    task automatic set_period_idle(input int v);
        cfg_we = 1'b1; cfg_period = v;
        step_cycle();
        cfg_we = 1'b0;
        step_cycle();
        step_cycle();
        m_period = clampp(v);
    endtask

    // Used with en = 1, well away from a tick: applies from the next tick.
    task automatic write_cfg_running(input int v);
        cfg_we = 1'b1; cfg_period = v;
        step_cycle();
        cfg_we = 1'b0;
        m_pend = clampp(v);
    endtask

    task automatic wait_latch(output int c, input int maxc);
        bit seen;
        seen = 0;
        c = -1;
        for (int i = 0; i < maxc && !seen; i++) begin
            step_cycle();
            if (enc_latch) begin
                seen = 1;
                c = cyc;
            end
        end
        if (!seen) chk("latch_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_commit(input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            step_cycle();
            seen = commit_now;
        end
        if (!seen) chk("commit_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, c3, c4, c5, c6, s, nl;
        word4_t exp3;

        vt[0] = '{in_v: mk4(4192, 4202, 4212, 4222), exp_v: mk4(0, 10, 20, 30)};
        vt[1] = '{in_v: mk4(4187, 0, 4192, 4193),
                  exp_v: mk4(32'hFFFF_FFFB, 32'hFFFF_EFA0, 0, 1)};
        vt[2] = '{in_v: mk4(5192, 32'hFFFF_FFFF, 32'h8000_1060, 4191),
                  exp_v: mk4(1000, 32'hFFFF_EF9F, 32'h8000_0000, 32'hFFFF_FFFF)};
        vt[3] = '{in_v: mk4(32'h8000_105F, 12345, 4192, 4200),
                  exp_v: mk4(32'h7FFF_FFFF, 8153, 0, 8)};

        reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_period = '0;
        frame_ack = 1'b0; rd_ch = '0;
        for (int k = 0; k < NUM_CH; k++) live_val[k] = '0;
        m_valid = 0; m_ovr = 0; m_cnt = '0; m_snap = '0;
        m_period = DEF_P; m_pend = 0; next_latch = -1; cap_pend = 0;

        // Reset state
        step_cycle();
        step_cycle();
        chk("reset_enc_sel", {30'd0, enc_sel}, 32'd0);
        chk("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        sweep_rd("reset_snapshot", '0);
        reset = 1'b0;
        $display("[TB] reset state checked");

        // Table-driven frames at period 100
        set_period_idle(100);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NUM_CH; k++) live_val[k] = vt[r].in_v[k];
            if (r == 0) set_en(1'b1);
            wait_commit(300);
            chk("latency", cyc - last_latch, LAT);
            sweep_rd("vector_rd", vt[r].exp_v);
            $display("[TB] vector %0d committed at cyc %0d, deltas %h %h %h %h",
                     r, cyc, rd_data, vt[r].exp_v[1], vt[r].exp_v[2], vt[r].exp_v[3]);
            frame_ack = 1'b1;
            step_cycle();
            frame_ack = 1'b0;
        end

        // Three unacknowledged frames
        set_en(1'b0);
        do_reset();
        set_period_idle(100);
        for (int fr = 1; fr <= 3; fr++) begin
            for (int k = 0; k < NUM_CH; k++) live_val[k] = OFFSET + 100 * fr + k;
            if (fr == 1) set_en(1'b1);
            wait_commit(300);
            chk("overrun_after_commit", {31'd0, overrun}, (fr >= 2) ? 32'd1 : 32'd0);
        end
        chk("frame_cnt_three", {16'd0, frame_cnt}, 32'd3);
        exp3 = mk4(300, 301, 302, 303);
        sweep_rd("third_frame", exp3);
        $display("[TB] overrun sequence: frame_cnt=%0d overrun=%0d", frame_cnt, overrun);

        // Ack exactly in the COMMIT cycle
        set_en(1'b0);
        do_reset();
        set_period_idle(100);
        set_en(1'b1);
        wait_commit(300);
        wait_latch(c0, 200);
        repeat (10) step_cycle();
        frame_ack = 1'b1;
        step_cycle();
        frame_ack = 1'b0;
        chk("commit_slot", {31'd0, commit_now}, 32'd1);
        chk("ack_at_commit_valid", {31'd0, frame_valid}, 32'd1);
        chk("ack_at_commit_overrun", {31'd0, overrun}, 32'd0);
        frame_ack = 1'b1;
        step_cycle();
        frame_ack = 1'b0;
        chk("ack_clears_valid", {31'd0, frame_valid}, 32'd0);
        $display("[TB] ack-in-commit sequence done at cyc %0d", cyc);

        // Period clamp and mid-period reconfiguration
        wait_latch(c1, 200);
        repeat (5) step_cycle();
        write_cfg_running(3);
        wait_latch(c2, 200);
        chk("period_unchanged", c2 - c1, 100);
        wait_latch(c3, 200);
        chk("period_clamped", c3 - c2, MINP);
        wait_latch(c4, 200);
        chk("period_clamped_2", c4 - c3, MINP);
        repeat (3) step_cycle();
        write_cfg_running(200);
        wait_latch(c5, 200);
        chk("period_mid_write", c5 - c4, MINP);
        wait_latch(c6, 300);
        chk("period_new", c6 - c5, 200);
        $display("[TB] period intervals %0d %0d %0d %0d %0d",
                 c2 - c1, c3 - c2, c4 - c3, c5 - c4, c6 - c5);

        // Reset during READ
        wait_latch(c0, 300);
        repeat (6) step_cycle();
        do_reset();
        s = cyc;
        chk("abort_frame_valid", {31'd0, frame_valid}, 32'd0);
        sweep_rd("abort_snapshot", '0);
        wait_latch(c1, DEF_P + 50);
        chk("first_latch_after_reset", c1 - s, DEF_P);
        $display("[TB] reset-in-read: first latch %0d cycles after release", c1 - s);

        // en dropped during SETTLE
        repeat (2) step_cycle();
        set_en(1'b0);
        wait_commit(30);
        chk("en_drop_commit_latency", cyc - c1, LAT);
        nl = n_latch;
        repeat (DEF_P + 20) step_cycle();
        chk("en_drop_no_latch", n_latch - nl, 0);
        $display("[TB] en-drop: frame committed, %0d further latches", n_latch - nl);

        // Randomised run against the reference model
        do_reset();
        set_period_idle($urandom_range(MINP, 40));
        set_en(1'b1);
        for (int i = 0; i < 3000; i++) begin
            live_val[$urandom_range(0, NUM_CH - 1)] = (i % 3 == 0) ? $urandom()
                                                     : OFFSET + $urandom_range(0, 64) - 32;
            frame_ack = ($urandom_range(0, 3) == 0);
            rd_ch     = SEL_W'($urandom_range(0, NUM_CH - 1));
            step_cycle();
        end
        frame_ack = 1'b0;
        $display("[TB] random run: period %0d, %0d frames committed", m_period, m_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
